// File: rtl/parity_seq.sv
// Parity sequencer: reads Len bytes, packs one parity bit per byte LSB-first, writes packed bytes.
// Optional macro PARITY_SEQ_ONES_TOTAL_EN adds OnesTotal, the set-bit count over the whole job.
module parity_seq #(
  parameter int unsigned AW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [AW-1:0] Len,
  output logic [AW-1:0] MemAddr,
  output logic          MemRdEn,
  input  logic [7:0]    MemRdData,
  output logic          MemWrEn,
  output logic [7:0]    MemWrData,
  output logic          Busy,
  output logic          Done
`ifdef PARITY_SEQ_ONES_TOTAL_EN
  ,
  output logic [AW+3:0] OnesTotal
`endif
);

  typedef enum logic [2:0] {StIdle, StRead, StCapt, StWrite, StDone} state_e;

  state_e        state;
  logic [AW-1:0] src_ptr;
  logic [AW-1:0] dst_ptr;
  logic [AW-1:0] remain;
  logic [2:0]    bit_idx;
  logic [7:0]    pack;

  logic          parity_bit;
  logic [7:0]    pack_next;
  logic [AW-1:0] src_next;
  logic          flush;

  always_comb begin
    parity_bit = ^MemRdData;
    pack_next  = pack | (8'(parity_bit) << bit_idx);
    src_next   = src_ptr + AW'(1);
    // Flush on the eighth packed bit or on the last byte of the job.
    flush      = (bit_idx == 3'd7) || (remain == AW'(1));
  end

`ifdef PARITY_SEQ_ONES_TOTAL_EN
  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + 4'(b[i]);
    return c;
  endfunction
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= StIdle;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remain    <= '0;
      bit_idx   <= '0;
      pack      <= '0;
      MemAddr   <= '0;
      MemRdEn   <= 1'b0;
      MemWrEn   <= 1'b0;
      MemWrData <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
`ifdef PARITY_SEQ_ONES_TOTAL_EN
      OnesTotal <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (Start) begin
            src_ptr <= SrcAddr;
            dst_ptr <= DstAddr;
            remain  <= Len;
            bit_idx <= '0;
            pack    <= '0;
            Busy    <= 1'b1;
`ifdef PARITY_SEQ_ONES_TOTAL_EN
            OnesTotal <= '0;
`endif
            if (Len != '0) begin
              state   <= StRead;
              MemRdEn <= 1'b1;
              MemAddr <= SrcAddr;
            end else begin
              state <= StDone;
              Done  <= 1'b1;
            end
          end
        end

        StRead: begin
          state   <= StCapt;
          MemRdEn <= 1'b0;
          MemAddr <= '0;
        end

        StCapt: begin
          pack    <= pack_next;
          src_ptr <= src_next;
          bit_idx <= bit_idx + 3'd1;
          remain  <= remain - AW'(1);
`ifdef PARITY_SEQ_ONES_TOTAL_EN
          OnesTotal <= OnesTotal + (AW+4)'(popcount8(MemRdData));
`endif
          if (flush) begin
            state     <= StWrite;
            MemWrEn   <= 1'b1;
            MemAddr   <= dst_ptr;
            MemWrData <= pack_next;
          end else begin
            state   <= StRead;
            MemRdEn <= 1'b1;
            MemAddr <= src_next;
          end
        end

        StWrite: begin
          MemWrEn   <= 1'b0;
          MemWrData <= '0;
          pack      <= '0;
          bit_idx   <= '0;
          dst_ptr   <= dst_ptr + AW'(1);
          if (remain == '0) begin
            state   <= StDone;
            MemAddr <= '0;
            Done    <= 1'b1;
          end else begin
            state   <= StRead;
            MemRdEn <= 1'b1;
            MemAddr <= src_ptr;
          end
        end

        StDone: begin
          state <= StIdle;
          Done  <= 1'b0;
          Busy  <= 1'b0;
        end

        default: begin
          state   <= StIdle;
          MemAddr <= '0;
          MemRdEn <= 1'b0;
          MemWrEn <= 1'b0;
          Busy    <= 1'b0;
          Done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_seq.sv
// Directed bench for parity_seq: latency, packed data, address wrap, mid-job reset, restart.
module tb_parity_seq;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] SrcAddr, DstAddr, Len;
  logic [7:0] MemAddr;
  logic       MemRdEn;
  logic [7:0] MemRdData;
  logic       MemWrEn;
  logic [7:0] MemWrData;
  logic       Busy;
  logic       Done;
`ifdef PARITY_SEQ_ONES_TOTAL_EN
  logic [11:0] OnesTotal;
`endif

  int tests = 0;
  int fails = 0;
  int viol  = 0;

  logic [7:0] mem [0:255];
  logic [7:0] rd_log[$];
  logic [7:0] wa_log[$];
  logic [7:0] wd_log[$];

  parity_seq #(.AW(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .SrcAddr   (SrcAddr),
    .DstAddr   (DstAddr),
    .Len       (Len),
    .MemAddr   (MemAddr),
    .MemRdEn   (MemRdEn),
    .MemRdData (MemRdData),
    .MemWrEn   (MemWrEn),
    .MemWrData (MemWrData),
    .Busy      (Busy),
    .Done      (Done)
`ifdef PARITY_SEQ_ONES_TOTAL_EN
    ,
    .OnesTotal (OnesTotal)
`endif
  );

  always #5 Clk = ~Clk;

  // Synchronous-read memory model.
  always @(posedge Clk) if (MemRdEn) MemRdData <= mem[MemAddr];

  always @(negedge Clk) begin
    if (MemRdEn) rd_log.push_back(MemAddr);
    if (MemWrEn) begin
      wa_log.push_back(MemAddr);
      wd_log.push_back(MemWrData);
    end
    if (MemRdEn && MemWrEn) viol++;
    if (!MemRdEn && !MemWrEn && (MemAddr !== 8'h00)) viol++;
    if (!MemWrEn && (MemWrData !== 8'h00)) viol++;
  end

  task automatic clear_logs();
    rd_log.delete();
    wa_log.delete();
    wd_log.delete();
  endtask

  // Launch a job; lat counts negedges after the Start-sampling edge until Done is seen.
  task automatic run_job(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                         output int lat);
    @(negedge Clk);
    SrcAddr = src; DstAddr = dst; Len = len; Start = 1'b1;
    @(posedge Clk);
    lat = 9999;
    for (int n = 1; n <= 400; n++) begin
      @(negedge Clk);
      Start = 1'b0;
      if (Done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; Len = '0;
    repeat (2) @(negedge Clk);
    tests++;
    if ({Busy, Done, MemRdEn, MemWrEn} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0000", {Busy, Done, MemRdEn, MemWrEn});
    end
    tests++;
    if ({MemAddr, MemWrData} !== 16'h0000) begin
      fails++; $display("FAIL reset_bus: got %h expected 0000", {MemAddr, MemWrData});
    end
    Reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    clear_logs();
    mem[8'h10] = 8'h01; mem[8'h11] = 8'h03; mem[8'h12] = 8'hFF;
    run_job(8'h10, 8'h80, 8'd3, lat);
    tests++;
    if (lat != 8) begin fails++; $display("FAIL basic_latency: got %0d expected 8", lat); end
    tests++;
    if (wa_log.size() != 1 || wa_log[0] !== 8'h80 || wd_log[0] !== 8'h01) begin
      fails++;
      $display("FAIL basic_write: got n=%0d addr=%h data=%h expected n=1 addr=80 data=01",
               wa_log.size(), wa_log[0], wd_log[0]);
    end
    tests++;
    if (rd_log.size() != 3 || rd_log[0] !== 8'h10 || rd_log[2] !== 8'h12) begin
      fails++; $display("FAIL basic_reads: got n=%0d first=%h expected n=3 first=10",
                        rd_log.size(), rd_log[0]);
    end
  endtask

  task automatic test_nine();
    int lat;
    clear_logs();
    for (int i = 0; i < 9; i++) mem[8'h20 + i] = 8'h07;
    run_job(8'h20, 8'h40, 8'd9, lat);
    tests++;
    if (lat != 21) begin fails++; $display("FAIL nine_latency: got %0d expected 21", lat); end
    tests++;
    if (wa_log.size() != 2 || wa_log[0] !== 8'h40 || wd_log[0] !== 8'hFF ||
        wa_log[1] !== 8'h41 || wd_log[1] !== 8'h01) begin
      fails++;
      $display("FAIL nine_writes: got n=%0d %h:%h %h:%h expected n=2 40:ff 41:01",
               wa_log.size(), wa_log[0], wd_log[0], wa_log[1], wd_log[1]);
    end
  endtask

  task automatic test_len_zero();
    int lat;
    clear_logs();
    run_job(8'h10, 8'h80, 8'd0, lat);
    tests++;
    if (lat != 1) begin fails++; $display("FAIL zero_latency: got %0d expected 1", lat); end
    @(negedge Clk);
    tests++;
    if (Busy !== 1'b0) begin fails++; $display("FAIL zero_busy: got %b expected 0", Busy); end
    tests++;
    if (rd_log.size() + wa_log.size() != 0) begin
      fails++; $display("FAIL zero_access: got %0d expected 0", rd_log.size() + wa_log.size());
    end
  endtask

  task automatic test_wrap();
    int lat;
    logic [7:0] exp_rd [4];
    exp_rd = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    mem[8'hFE] = 8'h03; mem[8'hFF] = 8'h01;
    for (int i = 0; i < 16; i++) mem[i] = (i % 2 == 0) ? 8'h01 : 8'h00;
    clear_logs();
    run_job(8'hFE, 8'h50, 8'd4, lat);
    tests++;
    if (rd_log.size() != 4 || rd_log[0] !== exp_rd[0] || rd_log[1] !== exp_rd[1] ||
        rd_log[2] !== exp_rd[2] || rd_log[3] !== exp_rd[3]) begin
      fails++; $display("FAIL wrap_reads: got n=%0d %h %h %h %h expected fe ff 00 01",
                        rd_log.size(), rd_log[0], rd_log[1], rd_log[2], rd_log[3]);
    end
    tests++;
    if (wd_log.size() != 1 || wd_log[0] !== 8'h06) begin
      fails++; $display("FAIL wrap_pack: got %h expected 06", wd_log[0]);
    end
    clear_logs();
    run_job(8'h00, 8'hFF, 8'd16, lat);
    tests++;
    if (lat != 35) begin fails++; $display("FAIL wrap16_latency: got %0d expected 35", lat); end
    tests++;
    if (wa_log.size() != 2 || wa_log[0] !== 8'hFF || wa_log[1] !== 8'h00 ||
        wd_log[0] !== 8'h55 || wd_log[1] !== 8'h55) begin
      fails++; $display("FAIL wrap_writes: got n=%0d %h:%h %h:%h expected ff:55 00:55",
                        wa_log.size(), wa_log[0], wd_log[0], wa_log[1], wd_log[1]);
    end
  endtask

  task automatic test_reset_mid_job();
    int lat;
    for (int i = 0; i < 8; i++) mem[8'h30 + i] = 8'h01;
    clear_logs();
    @(negedge Clk);
    SrcAddr = 8'h30; DstAddr = 8'h90; Len = 8'd8; Start = 1'b1;
    @(posedge Clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge Clk);
      if (n == 1) Start = 1'b0;
      if (n == 3) begin Start = 1'b1; SrcAddr = 8'hA0; Len = 8'd1; end
      if (n == 4) Start = 1'b0;
    end
    // Now in the fifth capture cycle.
    Reset = 1'b1;
    #1;
    tests++;
    if ({Busy, Done, MemRdEn, MemWrEn, MemAddr, MemWrData} !== 20'h0) begin
      fails++; $display("FAIL midreset_outputs: got %h expected 00000",
                        {Busy, Done, MemRdEn, MemWrEn, MemAddr, MemWrData});
    end
    @(negedge Clk);
    Reset = 1'b0;
    repeat (20) @(negedge Clk);
    tests++;
    if (wa_log.size() != 0) begin
      fails++; $display("FAIL midreset_nowrite: got %0d writes expected 0", wa_log.size());
    end
    tests++;
    if (rd_log.size() != 5 || rd_log[4] !== 8'h34) begin
      fails++; $display("FAIL busy_start_ignored: got n=%0d last=%h expected n=5 last=34",
                        rd_log.size(), rd_log[4]);
    end
    // Start on the first edge after reset release.
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    clear_logs();
    SrcAddr = 8'h30; DstAddr = 8'h91; Len = 8'd2; Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    tests++;
    if (MemRdEn !== 1'b1 || MemAddr !== 8'h30) begin
      fails++; $display("FAIL post_reset_start: got rd=%b addr=%h expected rd=1 addr=30",
                        MemRdEn, MemAddr);
    end
    lat = 9999;
    for (int n = 2; n <= 100; n++) begin
      @(negedge Clk);
      if (Done) begin lat = n; break; end
    end
    tests++;
    if (lat != 6 || wa_log.size() != 1 || wa_log[0] !== 8'h91 || wd_log[0] !== 8'h03) begin
      fails++; $display("FAIL post_reset_job: got lat=%0d n=%0d %h:%h expected lat=6 n=1 91:03",
                        lat, wa_log.size(), wa_log[0], wd_log[0]);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    mem[8'h50] = 8'h80;
    clear_logs();
    @(negedge Clk);
    SrcAddr = 8'h50; DstAddr = 8'h70; Len = 8'd1; Start = 1'b1;
    @(posedge Clk);
    lat1 = 9999;
    for (int n = 1; n <= 50; n++) begin
      @(negedge Clk);
      if (Done) begin lat1 = n; break; end
    end
    tests++;
    if (lat1 != 4) begin fails++; $display("FAIL b2b_latency1: got %0d expected 4", lat1); end
    @(negedge Clk);
    tests++;
    if (Busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: got busy=%b expected 0", Busy); end
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    tests++;
    if (MemRdEn !== 1'b1 || Busy !== 1'b1) begin
      fails++; $display("FAIL b2b_relaunch: got rd=%b busy=%b expected 1 1", MemRdEn, Busy);
    end
    lat2 = 9999;
    for (int n = 2; n <= 50; n++) begin
      @(negedge Clk);
      if (Done) begin lat2 = n; break; end
    end
    tests++;
    if (lat2 != 4 || wa_log.size() != 2 || wd_log[0] !== 8'h01 || wd_log[1] !== 8'h01) begin
      fails++; $display("FAIL b2b_second: got lat=%0d n=%0d expected lat=4 n=2 data 01",
                        lat2, wa_log.size());
    end
  endtask

`ifdef PARITY_SEQ_ONES_TOTAL_EN
  task automatic test_ones_total();
    int lat;
    mem[8'h60] = 8'hFF; mem[8'h61] = 8'h0F; mem[8'h62] = 8'h00;
    clear_logs();
    run_job(8'h60, 8'hC0, 8'd3, lat);
    tests++;
    if (OnesTotal !== 12'd12) begin
      fails++; $display("FAIL ones_total: got %0d expected 12", OnesTotal);
    end
    repeat (3) @(negedge Clk);
    tests++;
    if (OnesTotal !== 12'd12 || wd_log[0] !== 8'h00) begin
      fails++; $display("FAIL ones_hold: got %0d data=%h expected 12 data=00", OnesTotal, wd_log[0]);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    MemRdData = 8'h00;
    test_reset();
    test_basic();
    test_nine();
    test_len_zero();
    test_wrap();
    test_reset_mid_job();
    test_back_to_back();
`ifdef PARITY_SEQ_ONES_TOTAL_EN
    test_ones_total();
`endif
    tests++;
    if (viol != 0) begin
      fails++; $display("FAIL bus_idle_rules: got %0d violations expected 0", viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/parity_seq.md
PARITY_SEQ -- requirements
Module: parity_seq

Interface
REQ-001 The block SHALL have parameter AW, default 8, meaning width of memory addresses and of the length field.
REQ-002 The block SHALL have port Clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port Start, input, 1, sampled only in IDLE; launches a job.
REQ-005 The block SHALL have port SrcAddr, input, AW, first source byte address, latched on Start.
REQ-006 The block SHALL have port DstAddr, input, AW, first result byte address, latched on Start.
REQ-007 The block SHALL have port Len, input, AW, number of source bytes, latched on Start.
REQ-008 The block SHALL have port MemAddr, output, AW, the shared memory address.
REQ-009 The block SHALL have port MemRdEn, output, 1, the read strobe.
REQ-010 The block SHALL have port MemRdData, input, 8, read data, valid the cycle after MemRdEn (synchronous read).
REQ-011 The block SHALL have port MemWrEn, output, 1, the write strobe.
REQ-012 The block SHALL have port MemWrData, output, 8, packed parity byte.
REQ-013 The block SHALL have port Busy, output, 1, high in every state except IDLE.
REQ-014 The block SHALL have port Done, output, 1, a one-cycle completion pulse.

Function
REQ-015 The block SHALL implement the FSM states IDLE, READ, CAPT, WRITE and DONE.
REQ-016 In IDLE with Start=1, the block SHALL latch SrcAddr, DstAddr and Len, and go to READ if Len!=0, else to DONE.
REQ-017 In READ, the block SHALL drive MemRdEn=1 and MemAddr=current source pointer, then go to CAPT.
REQ-018 In CAPT, the block SHALL compute parity p = XOR of MemRdData[7:0] (1 = odd number of ones) and shift p into the pack register at bit position (byte index mod 8), LSB-first, then increment the source pointer and byte index.
REQ-019 After CAPT, the block SHALL go to WRITE if 8 bits are packed or the last byte has been captured; otherwise it SHALL go to READ.
REQ-020 In WRITE, the block SHALL drive MemWrEn=1, MemAddr=destination pointer and MemWrData=pack register (unfilled bits 0), then clear the pack register and increment the destination pointer; it SHALL go to DONE if all bytes are done, else to READ.
REQ-021 In DONE, the block SHALL assert Done=1 for exactly one cycle and return to IDLE.
REQ-022 MemRdEn and MemWrEn SHALL never be high in the same cycle; MemAddr, MemWrData and both strobes SHALL be 0 when no access is active.
REQ-023 Both pointers SHALL wrap modulo 2^AW with no error indication.
REQ-024 Start SHALL be ignored while Busy=1; a Start held high through DONE SHALL launch a new job on the first cycle back in IDLE.
REQ-025 The latency from the Start-sampling edge to Done high SHALL be 2N + ceil(N/8) + 1 cycles for N=Len; for Len=0 it SHALL be 1 cycle with no memory access.

Reset
REQ-026 Reset SHALL force IDLE asynchronously and clear the pack register, the pointers and all outputs to 0, including mid-job; a partially packed byte SHALL be discarded and never written.
REQ-027 After Reset is released, the block SHALL accept Start on the first rising edge.

Configuration
REQ-028 With macro PARITY_SEQ_ONES_TOTAL_EN defined, the block SHALL add output OnesTotal [AW+3:0], cleared on Start, accumulating the set-bit count of every captured byte, and held after Done until the next Start or Reset.
REQ-029 Without PARITY_SEQ_ONES_TOTAL_EN, the port and counter SHALL be absent, and all other behaviour and timing SHALL be identical.

Verification
REQ-030 Scenario: Len=3, Src=0x10 holding 0x01, 0x03, 0xFF, Dst=0x80 -> exactly one write, 0x01 to address 0x80; Done at cycle 8.
REQ-031 Scenario: Len=9, bytes 0x07 repeated (odd) -> writes 0xFF to Dst, then 0x01 to Dst+1; Done at cycle 21.
REQ-032 Scenario: Len=0 -> no MemRdEn or MemWrEn; Done pulses 1 cycle after Start; Busy high for that 1 cycle only.
REQ-033 Scenario: Src=0xFE, Len=4 -> reads at 0xFE, 0xFF, 0x00, 0x01; Dst=0xFF with Len=16 -> writes at 0xFF, then 0x00.
REQ-034 Scenario: Reset pulsed during the 5th CAPT of Len=8 -> no write occurs, outputs are 0, and a new Start runs correctly; Start pulses during Busy have no effect.
REQ-035 Scenario: PARITY_SEQ_ONES_TOTAL_EN defined, bytes 0xFF, 0x0F, 0x00 -> OnesTotal=12 at Done.
